// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin fetch/data arbiter for a single-ported DRAM
// Validates each word access at grant time and drives the DRAM strobes with optional wait states.
module dram_arbiter #(
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [31:0] MAX_ADDR  = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nx;
  logic [3:0]  cnt;
  logic        last_grant;   // 1 = data port won the previous grant
  logic        gnt_d;
  logic        lat_we;
  logic        lat_err;

  logic        grant;
  logic        pick_d;
  logic [31:0] sel_addr;
  logic        sel_we;
  logic        sel_err;

  // On a tie the port that did not win last time is served.
  assign grant    = (state == IDLE) && (if_req || d_req);
  assign pick_d   = d_req && (!if_req || !last_grant);
  assign sel_addr = pick_d ? d_addr : if_addr;
  assign sel_we   = pick_d && d_we;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    if_ack    = 1'b0;
    if_err    = 1'b0;
    d_ack     = 1'b0;
    d_err     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_nx = sel_err ? DONE : ACCESS;
      end
      ACCESS: begin
        mem_read  = !lat_we;
        mem_write = lat_we && (cnt == 4'd0);
        if (cnt == 4'd0) state_nx = DONE;
      end
      DONE: begin
        if_ack   = !gnt_d;
        if_err   = !gnt_d && lat_err;
        d_ack    = gnt_d;
        d_err    = gnt_d && lat_err;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= 4'd0;
      last_grant <= 1'b1;
      gnt_d      <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      if_rdata   <= 32'd0;
      d_rdata    <= 32'd0;
    end else begin
      if (grant) begin
        last_grant <= pick_d;
        gnt_d      <= pick_d;
        lat_we     <= sel_we;
        lat_err    <= sel_err;
        cnt        <= WAIT_INIT;
        // Rejected accesses never touch the DRAM-facing buses.
        if (!sel_err) begin
          mem_addr <= sel_addr;
          if (sel_we) mem_wdata <= d_wdata;
        end
      end else if (state == ACCESS) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!lat_we) begin
          if (gnt_d) d_rdata  <= mem_rdata;
          else       if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter
// Two instances (no wait states and three wait states), each on its own DRAM model.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        if_req0 = 0, d_req0 = 0, d_we0 = 0;
  logic [31:0] if_addr0 = 0, d_addr0 = 0, d_wdata0 = 0;
  logic        if_ack0, if_err0, d_ack0, d_err0, mem_read0, mem_write0, busy0;
  logic [31:0] if_rdata0, d_rdata0, mem_addr0, mem_wdata0, mem_rdata0;

  logic        if_req3 = 0, d_req3 = 0, d_we3 = 0;
  logic [31:0] if_addr3 = 0, d_addr3 = 0, d_wdata3 = 0;
  logic        if_ack3, if_err3, d_ack3, d_err3, mem_read3, mem_write3, busy3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem3 [0:255];

  dram_arbiter #(.MEM_BYTES(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req0), .if_addr(if_addr0), .if_ack(if_ack0), .if_err(if_err0), .if_rdata(if_rdata0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_ack(d_ack0), .d_err(d_err0), .d_rdata(d_rdata0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0)
  );

  dram_arbiter #(.MEM_BYTES(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_err(if_err3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_err(d_err3), .d_rdata(d_rdata3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  assign mem_rdata0 = mem0[mem_addr0[9:2]];
  assign mem_rdata3 = mem3[mem_addr3[9:2]];

  always @(posedge clk) begin
    if (mem_write0) mem0[mem_addr0[9:2]] <= mem_wdata0;
    if (mem_write3) mem3[mem_addr3[9:2]] <= mem_wdata3;
  end

  int wr0 = 0, rd0 = 0, wr3 = 0, rd3 = 0, dack3 = 0;
  always @(negedge clk) begin
    if (mem_write0) wr0++;
    if (mem_read0)  rd0++;
    if (mem_write3) wr3++;
    if (mem_read3)  rd3++;
    if (d_ack3)     dack3++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic last_err;

  task automatic d_txn(input bit u, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat);
    @(posedge clk); #1;
    if (!u) begin d_we0 = we; d_addr0 = addr; d_wdata0 = wdata; d_req0 = 1; end
    else    begin d_we3 = we; d_addr3 = addr; d_wdata3 = wdata; d_req3 = 1; end
    lat = -1;
    last_err = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if ((!u && d_ack0) || (u && d_ack3)) begin
        lat = c;
        last_err = u ? d_err3 : d_err0;
        break;
      end
    end
    d_req0 = 0;
    d_req3 = 0;
  endtask

  task automatic if_txn(input bit u, input logic [31:0] addr, output int lat);
    @(posedge clk); #1;
    if (!u) begin if_addr0 = addr; if_req0 = 1; end
    else    begin if_addr3 = addr; if_req3 = 1; end
    lat = -1;
    last_err = 1'bx;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if ((!u && if_ack0) || (u && if_ack3)) begin
        lat = c;
        last_err = u ? if_err3 : if_err0;
        break;
      end
    end
    if_req0 = 0;
    if_req3 = 0;
  endtask

  int lat, w_snap, r_snap, a_snap, nacks;
  int who [0:3];
  int cyc [0:3];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    mem0[0]   = 32'hA5A5A5A5;
    mem0[8]   = 32'h20202020;
    mem0[255] = 32'h0BADCAFE;
    mem3[16]  = 32'h40404040;
    mem3[32]  = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin who[i] = 9; cyc[i] = -1; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_d_ack", 32'(d_ack0), 32'd0);
    check("rst_mem_read", 32'(mem_read0), 32'd0);
    check("rst_mem_addr", mem_addr0, 32'd0);
    check("rst_if_rdata", if_rdata0, 32'd0);
    @(posedge clk); #1;
    rst = 0;

    // Simultaneous requests straight out of reset, both held through four grants.
    if_addr0 = 32'h0; d_addr0 = 32'h20; d_we0 = 0;
    if_req0 = 1; d_req0 = 1; nacks = 0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      if (if_ack0 && nacks < 4) begin who[nacks] = 0; cyc[nacks] = c; nacks++; end
      if (d_ack0 && nacks < 4)  begin who[nacks] = 1; cyc[nacks] = c; nacks++; end
    end
    if_req0 = 0; d_req0 = 0;
    check("rr_who0", 32'(who[0]), 32'd0);
    check("rr_cyc0", 32'(cyc[0]), 32'd2);
    check("rr_who1", 32'(who[1]), 32'd1);
    check("rr_cyc1", 32'(cyc[1]), 32'd5);
    check("rr_who2", 32'(who[2]), 32'd0);
    check("rr_cyc2", 32'(cyc[2]), 32'd8);
    check("rr_who3", 32'(who[3]), 32'd1);
    check("rr_cyc3", 32'(cyc[3]), 32'd11);
    check("rr_if_rdata", if_rdata0, 32'hA5A5A5A5);
    check("rr_d_rdata", d_rdata0, 32'h20202020);

    w_snap = wr0;
    d_txn(0, 1, 32'h10, 32'hDEADBEEF, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_err", 32'(last_err), 32'd0);
    check("wr_strobes", 32'(wr0 - w_snap), 32'd1);
    check("wr_mem", mem0[4], 32'hDEADBEEF);
    d_txn(0, 0, 32'h10, 32'h0, lat);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_data", d_rdata0, 32'hDEADBEEF);

    d_txn(0, 0, 32'h0, 32'h0, lat);
    check("rd0_data", d_rdata0, 32'hA5A5A5A5);
    d_txn(0, 1, 32'h4, 32'h11111111, lat);
    check("wr4_lat", 32'(lat), 32'd2);
    check("wr4_keep_rdata", d_rdata0, 32'hA5A5A5A5);
    check("wr4_mem", mem0[1], 32'h11111111);

    w_snap = wr0; r_snap = rd0;
    d_txn(0, 0, 32'h3FE, 32'h0, lat);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", 32'(last_err), 32'd1);
    d_txn(0, 0, 32'h400, 32'h0, lat);
    check("oor_lat", 32'(lat), 32'd1);
    check("oor_err", 32'(last_err), 32'd1);
    d_txn(0, 1, 32'h402, 32'h77777777, lat);
    check("oorw_err", 32'(last_err), 32'd1);
    check("err_no_read", 32'(rd0 - r_snap), 32'd0);
    check("err_no_write", 32'(wr0 - w_snap), 32'd0);
    check("err_keep_rdata", d_rdata0, 32'hA5A5A5A5);
    d_txn(0, 0, 32'h3FC, 32'h0, lat);
    check("top_lat", 32'(lat), 32'd2);
    check("top_err", 32'(last_err), 32'd0);
    check("top_data", d_rdata0, 32'h0BADCAFE);

    r_snap = rd3;
    if_txn(1, 32'h40, lat);
    check("w3_lat", 32'(lat), 32'd5);
    check("w3_reads", 32'(rd3 - r_snap), 32'd4);
    check("w3_rdata", if_rdata3, 32'h40404040);

    // Write aborted by reset during its second ACCESS cycle.
    w_snap = wr3; a_snap = dack3;
    @(posedge clk); #1;
    d_we3 = 1; d_addr3 = 32'h80; d_wdata3 = 32'h12345678; d_req3 = 1;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_busy_pre", 32'(busy3), 32'd1);
    check("abort_nowr_pre", 32'(mem_write3), 32'd0);
    rst = 1;
    #1;
    check("abort_busy", 32'(busy3), 32'd0);
    check("abort_ack", 32'(d_ack3), 32'd0);
    check("abort_wr", 32'(mem_write3), 32'd0);
    check("abort_addr", mem_addr3, 32'd0);
    check("abort_if_rdata", if_rdata3, 32'd0);
    d_req3 = 0;
    @(posedge clk); #1;
    rst = 0;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_ack", 32'(dack3 - a_snap), 32'd0);
    check("abort_no_write", 32'(wr3 - w_snap), 32'd0);
    d_txn(1, 0, 32'h80, 32'h0, lat);
    check("abort_rd_lat", 32'(lat), 32'd5);
    check("abort_rd_data", d_rdata3, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
